mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one external combinational 4x4 array multiplier between NUM_REQ requesters.
- Grants requesters round-robin and registers the operands onto the multiplier inputs.
- Samples the product after LAT cycles and returns it to the granted requester over a valid/ready response channel.
- Sits between the tile's operand sources and the multiplier instance; one operation is in flight at a time.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- WIDTH, 4, operand width; product is 2*WIDTH.
- LAT, 1, cycles from multiplier-operand update to product sampling (minimum 1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_a  input  NUM_REQ*WIDTH  packed multiplicands; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  packed multipliers, same packing as req_a.
- mul_a  output  WIDTH  registered operand to the shared multiplier.
- mul_b  output  WIDTH  registered operand to the shared multiplier.
- mul_p  input  2*WIDTH  product from the shared multiplier.
- rsp_valid  output  NUM_REQ  one-hot response valid.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- rsp_p  output  2*WIDTH  product for the requester flagged in rsp_valid.
- busy  output  1  high in any state other than IDLE.
- ops_done  output  8  count of completed response handshakes, wraps 255->0.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; rr_ptr, wait counter and grant index go to 0.
  - mul_a, mul_b, rsp_valid, rsp_p and ops_done go to 0; busy and req_ready are 0.
  - Reset mid-operation drops the operation silently; no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - grant = first i with req_valid[i] set, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant] is driven high combinationally that cycle; all other req_ready bits are 0.
  - If no req_valid bit is set, req_ready is all 0 and the FSM stays in IDLE.
  - On handshake at edge t: mul_a <= req_a[grant], mul_b <= req_b[grant], grant index stored, counter <= LAT, state <= WAIT.
- WAIT:
  - req_ready is all 0.
  - Counter decrements every cycle.
  - In the cycle the counter equals 1: rsp_p <= mul_p, rsp_valid[grant] <= 1, state <= RESP.
  - Result: rsp_valid first observed high LAT+1 cycles after the accept edge (t+2 for LAT=1).
- RESP:
  - rsp_valid and rsp_p are held stable until rsp_ready[grant] is high.
  - rsp_ready on non-granted bits is ignored.
  - On the handshake: rsp_valid <= 0, ops_done += 1, rr_ptr <= (grant+1) mod NUM_REQ, state <= IDLE.
  - No new request is accepted in the response-handshake cycle; the earliest next accept is the following cycle.
- Operand registers:
  - mul_a/mul_b hold their last values between operations.
  - They change only on an accept edge or on reset.
- Requester rules:
  - Requesters must hold req_a/req_b stable while req_valid is high and req_ready is low.
  - A requester dropping req_valid before it is granted is legal; it is simply not granted.
- Arithmetic: the block does no arithmetic on the product; rsp_p is mul_p exactly as sampled.
- Fairness: with every requester continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,...

Optional Feature:
- Macro: MULT_SHARE_ZERO_SKIP_EN.
- Defined:
  - On an accept where the selected req_a or req_b is 0, the FSM goes straight to RESP.
  - rsp_p <= 0 and rsp_valid[grant] <= 1 at the accept edge, so the response is visible at t+1.
  - mul_a/mul_b are not updated for that operation.
  - ops_done and rr_ptr update as normal on the response handshake.
- Undefined: zero operands take the normal WAIT path with normal latency.

Test Plan:
- LAT=1, req_valid=01, req_a[0]=3, req_b[0]=5, rsp_ready=11 -> req_ready=01 at t; rsp_valid=01 with rsp_p=15 at t+2; ops_done=1; busy low at t+3.
- After reset, both valid: req0 15x15, req1 7x9 -> responses in order req0 (225) then req1 (63). Next simultaneous pair is granted to req0 first (rr_ptr wrapped to 0).
- Response backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid/rsp_p stable, req_ready=00 throughout. Response completes on the cycle rsp_ready[grant] rises; a high rsp_ready on the other bit has no effect.
- rst_n low for one cycle while in WAIT -> next cycle all outputs 0 and state IDLE with no response. A subsequent 2x6 request returns 12 with normal latency.
- LAT=3, 9x11 -> mul_a=9, mul_b=11 from t+1; rsp_valid at t+4 with rsp_p=99.
- Zero operand 0x9:
  - With MULT_SHARE_ZERO_SKIP_EN: rsp_p=0 at t+1 and mul_a/mul_b unchanged.
  - Without the macro: rsp_p=0 at t+2.
  - 256 back-to-back completed ops -> ops_done returns to 0.

Source files
------------

// File: rtl/mult_share_if.sv
// Request/response channels between operand sources and the shared-multiplier arbiter.
// The master side is the requester tile; the slave side is mult_share_arbiter.
interface mult_share_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [2*WIDTH-1:0]       rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one external combinational multiplier; one op in flight.
// Optional MULT_SHARE_ZERO_SKIP_EN: zero operands bypass the multiplier and respond at once.
//
// state | meaning
// IDLE  | scanning requesters from rr_ptr, accept on handshake
// WAIT  | operands on multiplier, counting down LAT cycles
// RESP  | product held on rsp_p until the granted requester takes it
module mult_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 4,
  parameter int LAT     = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  mult_share_if.slave        bus,
  output logic [WIDTH-1:0]   mul_a_o,
  output logic [WIDTH-1:0]   mul_b_o,
  input  logic [2*WIDTH-1:0] mul_p_i,
  output logic               busy_o,
  output logic [7:0]         ops_done_o
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     grant_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     mul_a_q;
  logic [WIDTH-1:0]     mul_b_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [2*WIDTH-1:0]   rsp_p_q;
  logic [7:0]           ops_q;

  logic                 found_d;
  logic [IDX_W-1:0]     grant_d;
  logic [WIDTH-1:0]     sel_a_d;
  logic [WIDTH-1:0]     sel_b_d;
  logic                 zero_skip_d;

  // Scan downward so the entry nearest rr_ptr is the last (winning) assignment.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx     = '0;
    found_d = 1'b0;
    grant_d = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        found_d = 1'b1;
        grant_d = idx;
      end
    end
  end

  assign sel_a_d = bus.req_a[int'(grant_d)*WIDTH +: WIDTH];
  assign sel_b_d = bus.req_b[int'(grant_d)*WIDTH +: WIDTH];

`ifdef MULT_SHARE_ZERO_SKIP_EN
  assign zero_skip_d = (sel_a_d == '0) || (sel_b_d == '0);
`else
  assign zero_skip_d = 1'b0;
`endif

  always_comb begin
    bus.req_ready = '0;
    if (rst_n_i && (state_q == IDLE) && found_d) begin
      bus.req_ready[grant_d] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
      ops_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            grant_q <= grant_d;
            if (zero_skip_d) begin
              rsp_p_q              <= '0;
              rsp_valid_q[grant_d] <= 1'b1;
              state_q              <= RESP;
            end else begin
              mul_a_q <= sel_a_d;
              mul_b_q <= sel_b_d;
              cnt_q   <= CNT_W'(LAT);
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            rsp_p_q              <= mul_p_i;
            rsp_valid_q[grant_q] <= 1'b1;
            state_q              <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            ops_q       <= ops_q + 8'd1;
            rr_ptr_q    <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_p     = rsp_p_q;
  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;
  assign busy_o        = (state_q != IDLE);
  assign ops_done_o    = ops_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: a 2-requester LAT=1 instance and a 3-requester LAT=3 instance,
// directed steps plus a randomized phase against a transaction-level model.
module tb_mult_share_arbiter;
  localparam int W  = 4;
  localparam int N0 = 2;
  localparam int L0 = 1;
  localparam int N1 = 3;
  localparam int L1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_share_if #(.NUM_REQ(N0), .WIDTH(W)) if0 ();
  mult_share_if #(.NUM_REQ(N1), .WIDTH(W)) if1 ();

  logic [W-1:0]   m0a, m0b, m1a, m1b;
  logic [2*W-1:0] m0p, m1p;
  logic           busy0, busy1;
  logic [7:0]     ops0, ops1;

  assign m0p = (2*W)'(m0a) * (2*W)'(m0b);
  assign m1p = (2*W)'(m1a) * (2*W)'(m1b);

  mult_share_arbiter #(.NUM_REQ(N0), .WIDTH(W), .LAT(L0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if0),
    .mul_a_o(m0a), .mul_b_o(m0b), .mul_p_i(m0p),
    .busy_o(busy0), .ops_done_o(ops0)
  );

  mult_share_arbiter #(.NUM_REQ(N1), .WIDTH(W), .LAT(L1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if1),
    .mul_a_o(m1a), .mul_b_o(m1b), .mul_p_i(m1p),
    .busy_o(busy1), .ops_done_o(ops1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state for dut0
  int         m_ops = 0;
  int         m_ptr = 0;
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic skip_of(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_SHARE_ZERO_SKIP_EN
    return (a == '0) || (b == '0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] rop();
    return ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom_range(1, 15));
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    if0.req_valid = '0;
    if1.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ops = 0;
    m_ptr = 0;
    last_a = '0;
    last_b = '0;
  endtask

  // Caller has raised req_valid[g] with operands a/b at a negedge while dut0 is idle.
  task automatic issue0(input int g, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    logic         skip;
    int           lat;
    logic [7:0]   p;
    logic [1:0]   oth;
    skip = skip_of(a, b);
    lat  = skip ? 1 : L0 + 1;
    p    = skip ? 8'd0 : 8'(a) * 8'(b);
    oth  = ~(2'b01 << g);
    #1;
    chk("accept_ready", 32'(if0.req_ready), 32'(1 << g));
    if0.rsp_ready = (stall > 0) ? 2'b00 : 2'b11;
    @(negedge clk);
    if0.req_valid[g] = 1'b0;
    if (!skip) begin
      last_a = a;
      last_b = b;
    end
    chk("mul_a", 32'(m0a), 32'(last_a));
    chk("mul_b", 32'(m0b), 32'(last_b));
    chk("busy_op", 32'(busy0), 32'd1);
    for (int k = 1; k < lat; k++) begin
      chk("rsp_early", 32'(if0.rsp_valid), 32'd0);
      chk("ready_wait", 32'(if0.req_ready), 32'd0);
      @(negedge clk);
    end
    chk("rsp_valid", 32'(if0.rsp_valid), 32'(1 << g));
    chk("rsp_p", 32'(if0.rsp_p), 32'(p));
    for (int s = 0; s < stall; s++) begin
      if0.rsp_ready = (s % 2 == 1) ? oth : 2'b00;
      @(negedge clk);
      chk("stall_valid", 32'(if0.rsp_valid), 32'(1 << g));
      chk("stall_p", 32'(if0.rsp_p), 32'(p));
      chk("stall_ready", 32'(if0.req_ready), 32'd0);
    end
    if0.rsp_ready = 2'b11;
    @(negedge clk);
    m_ops++;
    m_ptr = (g + 1) % N0;
    chk("rsp_cleared", 32'(if0.rsp_valid), 32'd0);
    chk("busy_done", 32'(busy0), 32'd0);
    chk("ops_done", 32'(ops0), 32'(m_ops % 256));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N0-1:0]   rv;
    logic [N0*W-1:0] ra, rb;
    int              m_busy, m_g, m_cnt, exp_g, just;
    logic [7:0]      m_p;
    logic [W-1:0]    a, b;
    int              g;
    int              ops_start;

    if0.req_valid = '0; if0.req_a = '0; if0.req_b = '0; if0.rsp_ready = '0;
    if1.req_valid = '0; if1.req_a = '0; if1.req_b = '0; if1.rsp_ready = '0;

    // reset state
    do_reset();
    chk("rst_mul_a", 32'(m0a), 32'd0);
    chk("rst_mul_b", 32'(m0b), 32'd0);
    chk("rst_rsp_valid", 32'(if0.rsp_valid), 32'd0);
    chk("rst_rsp_p", 32'(if0.rsp_p), 32'd0);
    chk("rst_ops", 32'(ops0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ready", 32'(if0.req_ready), 32'd0);
    chk("rst1_busy", 32'(busy1), 32'd0);
    chk("rst1_rsp", 32'(if1.rsp_valid), 32'd0);

    // 3x5 single op
    if0.req_a = {4'd0, 4'd3}; if0.req_b = {4'd0, 4'd5}; if0.req_valid = 2'b01;
    issue0(0, 4'd3, 4'd5, 0);

    // both valid after reset, then wrap of rr_ptr back to 0
    do_reset();
    if0.req_a = {4'd7, 4'd15}; if0.req_b = {4'd9, 4'd15}; if0.req_valid = 2'b11;
    issue0(0, 4'd15, 4'd15, 0);
    issue0(1, 4'd7, 4'd9, 0);
    if0.req_valid = 2'b11;
    issue0(0, 4'd15, 4'd15, 0);
    issue0(1, 4'd7, 4'd9, 0);

    // response backpressure
    if0.req_a = {4'd8, 4'd4}; if0.req_b = {4'd13, 4'd6}; if0.req_valid = 2'b01;
    issue0(0, 4'd4, 4'd6, 5);
    if0.req_valid = 2'b10;
    issue0(1, 4'd8, 4'd13, 3);

    // reset while in WAIT drops the op
    if0.req_a = {4'd0, 4'd2}; if0.req_b = {4'd0, 4'd3}; if0.req_valid = 2'b01;
    #1 chk("rstw_ready", 32'(if0.req_ready), 32'd1);
    @(negedge clk);
    if0.req_valid = 2'b00;
    chk("rstw_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ops = 0; m_ptr = 0; last_a = '0; last_b = '0;
    chk("rstw_mul_a", 32'(m0a), 32'd0);
    chk("rstw_mul_b", 32'(m0b), 32'd0);
    chk("rstw_busy0", 32'(busy0), 32'd0);
    chk("rstw_ops", 32'(ops0), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("rstw_no_rsp", 32'(if0.rsp_valid), 32'd0);
      chk("rstw_rsp_p", 32'(if0.rsp_p), 32'd0);
      @(negedge clk);
    end
    if0.req_a = {4'd0, 4'd2}; if0.req_b = {4'd0, 4'd6}; if0.req_valid = 2'b01;
    issue0(0, 4'd2, 4'd6, 0);

    // zero operands
    if0.req_a = {4'd9, 4'd0}; if0.req_b = {4'd0, 4'd9}; if0.req_valid = 2'b01;
    issue0(0, 4'd0, 4'd9, 0);
    if0.req_valid = 2'b10;
    issue0(1, 4'd9, 4'd0, 0);

    // 256 completed ops wraps ops_done
    ops_start = m_ops;
    for (int k = 0; k < 256; k++) begin
      g = k % N0;
      a = rop();
      b = rop();
      if0.req_a[g*W +: W] = a;
      if0.req_b[g*W +: W] = b;
      if0.req_valid = N0'(1 << g);
      issue0(g, a, b, 0);
    end
    chk("ops_wrap", 32'(ops0), 32'(ops_start % 256));

    // randomized traffic against the transaction model
    rv = '0; ra = if0.req_a; rb = if0.req_b;
    m_busy = 0; m_g = 0; m_cnt = 0; just = 0; m_p = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      chk("rnd_ops", 32'(ops0), 32'(m_ops % 256));
      if (just != 0) begin
        rv[m_g] = 1'b0;
        just = 0;
      end
      if (cyc >= 380) begin
        rv = '0;
      end else begin
        for (int i = 0; i < N0; i++) begin
          if (!rv[i]) begin
            if ($urandom_range(0, 2) == 0) begin
              rv[i] = 1'b1;
              ra[i*W +: W] = rop();
              rb[i*W +: W] = rop();
            end
          end else if (m_busy == 0 && $urandom_range(0, 7) == 0) begin
            rv[i] = 1'b0;
          end
        end
      end
      if0.req_valid = rv; if0.req_a = ra; if0.req_b = rb;
      if0.rsp_ready = (cyc >= 380) ? 2'b11 : 2'($urandom_range(0, 3));
      #1;
      if (m_busy == 0) begin
        exp_g = -1;
        for (int k = 0; k < N0; k++) begin
          if (exp_g < 0 && rv[(m_ptr + k) % N0]) exp_g = (m_ptr + k) % N0;
        end
        chk("rnd_idle_busy", 32'(busy0), 32'd0);
        chk("rnd_ready", 32'(if0.req_ready), (exp_g < 0) ? 32'd0 : 32'(1 << exp_g));
        if (exp_g >= 0) begin
          a = ra[exp_g*W +: W];
          b = rb[exp_g*W +: W];
          m_g = exp_g;
          m_busy = 1;
          just = 1;
          m_p = skip_of(a, b) ? 8'd0 : 8'(a) * 8'(b);
          m_cnt = skip_of(a, b) ? 1 : L0 + 1;
          if (!skip_of(a, b)) begin
            last_a = a;
            last_b = b;
          end
        end
      end else begin
        if (m_cnt > 0) m_cnt--;
        chk("rnd_busy", 32'(busy0), 32'd1);
        chk("rnd_ready_busy", 32'(if0.req_ready), 32'd0);
        chk("rnd_mul_a", 32'(m0a), 32'(last_a));
        chk("rnd_mul_b", 32'(m0b), 32'(last_b));
        if (m_cnt > 0) begin
          chk("rnd_rsp_early", 32'(if0.rsp_valid), 32'd0);
        end else begin
          chk("rnd_rsp_valid", 32'(if0.rsp_valid), 32'(1 << m_g));
          chk("rnd_rsp_p", 32'(if0.rsp_p), 32'(m_p));
          if (if0.rsp_ready[m_g]) begin
            m_busy = 0;
            m_ops++;
            m_ptr = (m_g + 1) % N0;
          end
        end
      end
    end
    @(negedge clk);
    chk("rnd_drained", 32'(busy0), 32'd0);
    chk("rnd_ops_final", 32'(ops0), 32'(m_ops % 256));

    // LAT=3 instance: 9x11
    if1.req_a = 12'h009; if1.req_b = 12'h00B; if1.rsp_ready = 3'b111; if1.req_valid = 3'b001;
    #1 chk("l3_ready", 32'(if1.req_ready), 32'd1);
    @(negedge clk);
    if1.req_valid = 3'b000;
    chk("l3_mul_a", 32'(m1a), 32'd9);
    chk("l3_mul_b", 32'(m1b), 32'd11);
    for (int k = 1; k < L1 + 1; k++) begin
      chk("l3_rsp_early", 32'(if1.rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk("l3_rsp_valid", 32'(if1.rsp_valid), 32'd1);
    chk("l3_rsp_p", 32'(if1.rsp_p), 32'd99);
    @(negedge clk);
    chk("l3_busy_done", 32'(busy1), 32'd0);
    chk("l3_ops", 32'(ops1), 32'd1);

    // fairness with all three continuously valid; pointer now at 1
    if1.req_a = {4'd13, 4'd5, 4'd2};
    if1.req_b = {4'd11, 4'd7, 4'd3};
    if1.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_g = (1 + k) % N1;
      #1 chk("rot_ready", 32'(if1.req_ready), 32'(1 << exp_g));
      repeat (L1 + 1) @(negedge clk);
      chk("rot_rsp_valid", 32'(if1.rsp_valid), 32'(1 << exp_g));
      chk("rot_rsp_p", 32'(if1.rsp_p),
          32'(8'(if1.req_a[exp_g*W +: W]) * 8'(if1.req_b[exp_g*W +: W])));
      @(negedge clk);
    end
    if1.req_valid = 3'b000;
    chk("rot_ops", 32'(ops1), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
